// File: rtl/eth_nto1_pkt_mux.sv
// N-to-1 Avalon-ST packet aggregator: packet-atomic round-robin over NUM_PORTS streams,
// a single output register stage, source-port tagging and orphan-beat discard.
module eth_nto1_pkt_mux #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64,
  parameter int EMPTY_W   = 3,
  parameter int CHAN_W    = 8
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic [NUM_PORTS*DATA_W-1:0]  in_data,
  input  logic [NUM_PORTS-1:0]         in_valid,
  output logic [NUM_PORTS-1:0]         in_ready,
  input  logic [NUM_PORTS-1:0]         in_sop,
  input  logic [NUM_PORTS-1:0]         in_eop,
  input  logic [NUM_PORTS*EMPTY_W-1:0] in_empty,
  input  logic [NUM_PORTS-1:0]         port_enable,
  input  logic                         freeze,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_sop,
  output logic                         out_eop,
  output logic [EMPTY_W-1:0]           out_empty,
  output logic [CHAN_W-1:0]            out_channel,
  output logic                         busy,
  output logic [15:0]                  orphan_cnt
);
  localparam int GW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(NUM_PORTS + 1);

  typedef enum logic {IDLE, PASS} state_t;

  state_t               state;
  logic [GW-1:0]        grant;
  logic [GW-1:0]        last_grant;
  logic [GW-1:0]        next_grant;
  logic [GW-1:0]        g_hi;
  logic [GW-1:0]        g_lo;
  logic                 found_hi;
  logic                 found_lo;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] orphan;
  logic [CW-1:0]        orphan_num;
  logic [16:0]          orphan_sum;
  logic                 sp;
  logic                 take;

  assign sp         = !out_valid || out_ready;
  assign take       = (state == PASS) && in_valid[grant] && sp;
  assign busy       = (state == PASS) || out_valid;
  assign eligible   = in_valid & in_sop & port_enable & {NUM_PORTS{!freeze}};
  assign orphan     = (state == IDLE && !freeze) ? (in_valid & ~in_sop) : '0;
  assign orphan_sum = {1'b0, orphan_cnt} + 17'(orphan_num);

  // Round-robin: lowest eligible index above last_grant wins, otherwise wrap to the lowest overall.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    found_hi = 1'b0;
    found_lo = 1'b0;
    g_hi     = '0;
    g_lo     = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (eligible[p]) begin
        if (p > int'(last_grant)) begin
          found_hi = 1'b1;
          g_hi     = GW'(p);
        end else begin
          found_lo = 1'b1;
          g_lo     = GW'(p);
        end
      end
    end
    next_grant = found_hi ? g_hi : g_lo;
  end

  always_comb begin
    orphan_num = '0;
    for (int p = 0; p < NUM_PORTS; p++) orphan_num = orphan_num + CW'(orphan[p]);
  end

  // Only the granted port is back-pressured by the output register; orphans are swallowed in IDLE.
  always_comb begin
    in_ready = '0;
    if (!reset_reset) begin
      if (state == PASS) in_ready[grant] = sp;
      else               in_ready = orphan;
    end
  end

  always_ff @(posedge clk_clk) begin
    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    if (reset_reset) begin
      state       <= IDLE;
      grant       <= '0;
      last_grant  <= GW'(NUM_PORTS - 1);
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_empty   <= '0;
      out_channel <= '0;
      orphan_cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (found_hi || found_lo) begin
          grant <= next_grant;
          state <= PASS;
        end
        PASS: if (take && in_eop[grant]) begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (take) begin
        out_valid   <= 1'b1;
        out_data    <= in_data[grant*DATA_W +: DATA_W];
        out_sop     <= in_sop[grant];
        out_eop     <= in_eop[grant];
        out_empty   <= in_eop[grant] ? in_empty[grant*EMPTY_W +: EMPTY_W] : '0;
        out_channel <= CHAN_W'(grant);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      orphan_cnt <= orphan_sum[16] ? 16'hFFFF : orphan_sum[15:0];
    end
  end
endmodule

// File: tb/tb_eth_nto1_pkt_mux.sv
// Scoreboard bench for eth_nto1_pkt_mux: per-port source queues feed the DUT, expected beats
// are queued in predicted arbitration order and compared as the output hands them over.
module tb_eth_nto1_pkt_mux;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int EW = 3;
  localparam int CH = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [CH-1:0] chan;
  } beat_t;

  logic             clk;
  logic             reset_reset = 1'b1;
  logic [NP*DW-1:0] in_data     = '0;
  logic [NP-1:0]    in_valid    = '0;
  logic [NP-1:0]    in_ready;
  logic [NP-1:0]    in_sop      = '0;
  logic [NP-1:0]    in_eop      = '0;
  logic [NP*EW-1:0] in_empty    = '0;
  logic [NP-1:0]    port_enable = '1;
  logic             freeze      = 1'b0;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready   = 1'b1;
  logic             out_sop;
  logic             out_eop;
  logic [EW-1:0]    out_empty;
  logic [CH-1:0]    out_channel;
  logic             busy;
  logic [15:0]      orphan_cnt;

  eth_nto1_pkt_mux #(.NUM_PORTS(NP), .DATA_W(DW), .EMPTY_W(EW), .CHAN_W(CH)) dut (
    .clk_clk     (clk),
    .reset_reset (reset_reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_empty    (in_empty),
    .port_enable (port_enable),
    .freeze      (freeze),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_empty   (out_empty),
    .out_channel (out_channel),
    .busy        (busy),
    .orphan_cnt  (orphan_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int    vectors     = 0;
  int    miscompares = 0;
  int    uid         = 0;
  int    pkt_id      = 0;
  int    cyc         = 0;
  int    out_cnt     = 0;
  int    acc_cnt[NP] = '{default: 0};
  int    last_cyc    = 0;
  bit    have_last   = 1'b0;
  bit    gap_check   = 1'b0;
  logic [NP-1:0] acc = '0;
  beat_t pq[NP][$];
  beat_t exp_q[$];
  beat_t db;
  beat_t mb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic push_pkt(input int p, input int len, input logic [EW-1:0] emp, input bit orphan);
    beat_t b;
    beat_t e;
    for (int i = 0; i < len; i++) begin
      b.data  = {8'hA5, 8'(pkt_id), 8'(p), 8'(i), 32'(uid)};
      uid++;
      b.sop   = !orphan && (i == 0);
      b.eop   = !orphan && (i == len - 1);
      b.empty = b.eop ? emp : EW'(i + 1);
      b.chan  = CH'(p);
      pq[p].push_back(b);
      if (!orphan) begin
        e = b;
        if (!e.eop) e.empty = '0;
        exp_q.push_back(e);
      end
    end
    pkt_id++;
  endtask

  function automatic bit src_busy();
    for (int p = 0; p < NP; p++) if (pq[p].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic flush();
    for (int p = 0; p < NP; p++) pq[p].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_reset = 1'b1;
    flush();
    freeze      = 1'b0;
    out_ready   = 1'b1;
    port_enable = '1;
    repeat (2) @(negedge clk);
    reset_reset = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || src_busy()) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", (n < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_acc(input int p, input int target, input int budget);
    int n = 0;
    while (acc_cnt[p] < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("acc_timeout", (n < budget), 1);
  endtask

  task automatic wait_out(input int target, input int budget);
    int n = 0;
    while (out_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("out_timeout", (n < budget), 1);
  endtask

  task automatic wait_exp(input int sz, input int budget);
    int n = 0;
    while (exp_q.size() > sz && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("exp_timeout", (n < budget), 1);
  endtask

  // Source drivers and output monitor: drive on negedge, sample handshakes 1 ns before posedge.
  initial begin : driver
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (acc[p] === 1'b1 && pq[p].size() > 0) void'(pq[p].pop_front());
        if (pq[p].size() > 0) begin
          db = pq[p][0];
          in_valid[p]             = 1'b1;
          in_data[p*DW +: DW]     = db.data;
          in_sop[p]               = db.sop;
          in_eop[p]               = db.eop;
          in_empty[p*EW +: EW]    = db.empty;
        end else begin
          in_valid[p]             = 1'b0;
          in_sop[p]               = 1'b0;
          in_eop[p]               = 1'b0;
        end
      end
      #4;
      cyc++;
      acc = in_valid & in_ready;
      for (int p = 0; p < NP; p++) if (acc[p] === 1'b1) acc_cnt[p]++;
      if (out_valid === 1'b1 && out_ready && !reset_reset) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", out_data, 64'h0);
        end else begin
          mb = exp_q.pop_front();
          check("out_data", out_data, mb.data);
          check("out_ctl", {out_sop, out_eop, out_empty, out_channel}, {mb.sop, mb.eop, mb.empty, mb.chan});
          if (gap_check && have_last) begin
            if (mb.sop) check("gap_cycles", cyc - last_cyc, 2);
            else        check("contig_cycles", cyc - last_cyc, 1);
          end
          have_last = 1'b1;
          last_cyc  = cyc;
        end
        out_cnt++;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: time limit reached after %0d vectors", vectors);
    $fatal(1, "simulation time limit");
  end

  initial begin : main
    int base;

    // Reset values
    do_reset();
    #4;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ctl", {out_sop, out_eop, out_empty, out_channel}, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_orphan_cnt", orphan_cnt, 0);

    // 1: all four ports at once, order 0,1,2,3 with a one-cycle gap between packets
    have_last = 1'b0;
    gap_check = 1'b1;
    for (int p = 0; p < NP; p++) push_pkt(p, 4, EW'(p + 1), 1'b0);
    wait_drain(200);
    gap_check = 1'b0;

    // 2: make last_grant=1, then port 2 back-to-back against pending 3,0,1
    push_pkt(1, 2, 3'd1, 1'b0);
    wait_drain(100);
    have_last = 1'b0;
    gap_check = 1'b1;
    push_pkt(2, 3, 3'd2, 1'b0);
    push_pkt(3, 2, 3'd3, 1'b0);
    push_pkt(0, 2, 3'd4, 1'b0);
    push_pkt(1, 3, 3'd5, 1'b0);
    push_pkt(2, 2, 3'd6, 1'b0);
    wait_drain(300);
    gap_check = 1'b0;

    // Disabled port is skipped until re-enabled
    port_enable = 4'b1110;
    push_pkt(1, 2, 3'd7, 1'b0);
    push_pkt(0, 2, 3'd0, 1'b0);
    wait_exp(2, 100);
    repeat (4) @(negedge clk);
    #4;
    check("disabled_no_grant", out_valid, 0);
    @(negedge clk);
    port_enable = '1;
    wait_drain(100);

    // 3: stall mid-packet with out_ready 1,0,0,1
    base = out_cnt;
    push_pkt(0, 6, 3'd2, 1'b0);
    wait_out(base + 2, 100);
    out_ready = 1'b0;
    #4;
    check("stall_valid", out_valid, 1);
    check("stall_in_ready", in_ready[0], 0);
    check("stall_hold_data", out_data, exp_q[0].data);
    @(negedge clk);
    #4;
    check("stall2_in_ready", in_ready[0], 0);
    check("stall2_hold_data", out_data, exp_q[0].data);
    check("stall2_hold_ctl", {out_sop, out_eop}, {exp_q[0].sop, exp_q[0].eop});
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain(100);

    // 4: freeze rises mid-packet, packet completes; grant resumes two cycles after release
    push_pkt(1, 5, 3'd5, 1'b0);
    base = acc_cnt[1];
    wait_acc(1, base + 2, 100);
    freeze = 1'b1;
    push_pkt(2, 3, 3'd1, 1'b0);
    wait_exp(3, 100);
    repeat (5) @(negedge clk);
    #4;
    check("freeze_no_valid", out_valid, 0);
    check("freeze_busy", busy, 0);
    check("freeze_in_ready", in_ready[2], 0);
    @(negedge clk);
    freeze = 1'b0;
    #4;
    check("resume_c0_valid", out_valid, 0);
    @(negedge clk);
    #4;
    check("resume_c1_in_ready", in_ready[2], 1);
    check("resume_c1_valid", out_valid, 0);
    @(negedge clk);
    #4;
    check("resume_c2_valid", out_valid, 1);
    wait_drain(100);

    // 5: orphan beats in IDLE are swallowed and counted
    base = out_cnt;
    push_pkt(3, 3, 3'd0, 1'b1);
    wait_drain(100);
    check("orphan_cnt3", orphan_cnt, 16'd3);
    check("orphan_no_output", out_cnt - base, 0);
    check("orphan_busy", busy, 0);

    do_reset();
    #4;
    check("rst2_orphan_cnt", orphan_cnt, 0);
    push_pkt(0, 16384, 3'd0, 1'b1);
    push_pkt(1, 16384, 3'd0, 1'b1);
    push_pkt(2, 16383, 3'd0, 1'b1);
    push_pkt(3, 16383, 3'd0, 1'b1);
    wait_drain(20000);
    check("orphan_cnt_fffe", orphan_cnt, 16'hFFFE);
    for (int p = 1; p < NP; p++) push_pkt(p, 1, 3'd0, 1'b1);
    wait_drain(100);
    check("orphan_cnt_sat", orphan_cnt, 16'hFFFF);

    // 6: reset on beat 3 of a port-1 packet drops it; port 0 then wins first
    do_reset();
    push_pkt(1, 6, 3'd3, 1'b0);
    base = acc_cnt[1];
    wait_acc(1, base + 3, 100);
    reset_reset = 1'b1;
    flush();
    @(negedge clk);
    reset_reset = 1'b0;
    #4;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_busy", busy, 0);
    push_pkt(0, 2, 3'd4, 1'b0);
    push_pkt(1, 3, 3'd6, 1'b0);
    wait_drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
